// File: rtl/pixel_write_arbiter_if.sv
// Requester-side pixel handshake bundle between the renderers and the arbiter.
// Each requester owns one slice of the packed coordinate/colour vectors.
interface pixel_write_arbiter_if #(
  parameter int NUM_REQ = 4
);
  logic [NUM_REQ-1:0]   req;
  logic [NUM_REQ-1:0]   lock;
  logic [9*NUM_REQ-1:0] req_x;
  logic [8*NUM_REQ-1:0] req_y;
  logic [3*NUM_REQ-1:0] req_colour;
  logic [NUM_REQ-1:0]   ack;

  modport master (output req, lock, req_x, req_y, req_colour, input ack);
  modport slave  (input req, lock, req_x, req_y, req_colour, output ack);
endinterface

// File: rtl/pixel_write_arbiter.sv
// Round-robin arbiter with burst locking that shares the VGA adapter's single pixel port.
// Off-screen pixels are acked but dropped and counted; on-screen pixels are registered out.
module pixel_write_arbiter #(
  parameter  int NUM_REQ   = 4,
  parameter  int SCREEN_W  = 160,
  parameter  int SCREEN_H  = 120,
  parameter  int MAX_BURST = 25,
  localparam int OW        = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1,
  localparam int BW        = $clog2(MAX_BURST + 1)
) (
  input  logic                        clk,
  input  logic                        reset,
  pixel_write_arbiter_if.slave        i_reqBus,
  output logic [8:0]                  o_pixel_x,
  output logic [7:0]                  o_pixel_y,
  output logic [2:0]                  o_pixel_colour,
  output logic                        o_plot_enable,
  output logic [OW-1:0]               o_owner,
  output logic [7:0]                  o_drop_count
);

  typedef enum logic {FREE, OWNED} state_t;

  state_t        r_state, w_stateNext;
  logic [OW-1:0] r_owner, w_ownerNext;
  logic [BW-1:0] r_burstCnt, w_burstNext;
  logic [8:0]    r_pixelX;
  logic [7:0]    r_pixelY;
  logic [2:0]    r_pixelColour;
  logic          r_plotEnable;
  logic [7:0]    r_dropCount;

  logic          w_allFound, w_otherFound;
  logic [OW-1:0] w_allWinner, w_otherWinner;
  logic          w_take;
  logic [OW-1:0] w_takeIdx;
  logic          w_grant;
  logic [OW-1:0] w_grantIdx;
  logic [8:0]    w_gx;
  logic [7:0]    w_gy;
  logic [2:0]    w_gc;
  logic          w_onScreen;

  // Descending scan so the requester closest after owner is the last (winning) assignment.
  always_comb begin
    int idx;
    w_allFound    = 1'b0;
    w_allWinner   = r_owner;
    w_otherFound  = 1'b0;
    w_otherWinner = r_owner;
    idx           = 0;
    for (int k = NUM_REQ; k >= 1; k--) begin
      idx = (int'(r_owner) + k) % NUM_REQ;
      if (i_reqBus.req[idx]) begin
        w_allFound  = 1'b1;
        w_allWinner = OW'(idx);
        if (k != NUM_REQ) begin
          w_otherFound  = 1'b1;
          w_otherWinner = OW'(idx);
        end
      end
    end
  end

  always_comb begin
    w_stateNext = r_state;
    w_ownerNext = r_owner;
    w_burstNext = r_burstCnt;
    w_take      = 1'b0;
    w_takeIdx   = r_owner;
    w_grant     = 1'b0;
    w_grantIdx  = r_owner;
    unique case (r_state)
      FREE: begin
        w_take    = w_allFound;
        w_takeIdx = w_allWinner;
      end
      OWNED: begin
        if (!i_reqBus.lock[r_owner]) begin
          w_take      = w_allFound;
          w_takeIdx   = w_allWinner;
          w_stateNext = FREE;
          w_burstNext = '0;
        end else if (r_burstCnt >= BW'(MAX_BURST)) begin
          if (w_otherFound) begin
            w_take    = 1'b1;
            w_takeIdx = w_otherWinner;
          end else if (i_reqBus.req[r_owner]) begin
            w_grant     = 1'b1;
            w_burstNext = BW'(1);
          end
        end else if (i_reqBus.req[r_owner]) begin
          w_grant     = 1'b1;
          w_burstNext = r_burstCnt + BW'(1);
        end
      end
      default: ;
    endcase
    // A fresh winner starts a new burst only if it asks to keep the port.
    if (w_take) begin
      w_grant     = 1'b1;
      w_grantIdx  = w_takeIdx;
      w_ownerNext = w_takeIdx;
      if (i_reqBus.lock[w_takeIdx]) begin
        w_stateNext = OWNED;
        w_burstNext = BW'(1);
      end else begin
        w_stateNext = FREE;
        w_burstNext = '0;
      end
    end
  end

  always_comb begin
    w_gx       = i_reqBus.req_x[9*int'(w_grantIdx) +: 9];
    w_gy       = i_reqBus.req_y[8*int'(w_grantIdx) +: 8];
    w_gc       = i_reqBus.req_colour[3*int'(w_grantIdx) +: 3];
    w_onScreen = (w_gx < 9'(SCREEN_W)) && (w_gy < 8'(SCREEN_H));
  end

  always_comb begin
    i_reqBus.ack = '0;
    if (w_grant && !reset) begin
      i_reqBus.ack[w_grantIdx] = 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state       <= FREE;
      r_owner       <= OW'(NUM_REQ - 1);
      r_burstCnt    <= '0;
      r_pixelX      <= '0;
      r_pixelY      <= '0;
      r_pixelColour <= '0;
      r_plotEnable  <= 1'b0;
      r_dropCount   <= '0;
    end else begin
      r_state      <= w_stateNext;
      r_owner      <= w_ownerNext;
      r_burstCnt   <= w_burstNext;
      r_plotEnable <= w_grant && w_onScreen;
      if (w_grant && w_onScreen) begin
        r_pixelX      <= w_gx;
        r_pixelY      <= w_gy;
        r_pixelColour <= w_gc;
      end
      if (w_grant && !w_onScreen && (r_dropCount != 8'hFF)) begin
        r_dropCount <= r_dropCount + 8'd1;
      end
    end
  end

  assign o_pixel_x      = r_pixelX;
  assign o_pixel_y      = r_pixelY;
  assign o_pixel_colour = r_pixelColour;
  assign o_plot_enable  = r_plotEnable;
  assign o_drop_count   = r_dropCount;
  assign o_owner        = (w_grant && !reset) ? w_grantIdx : r_owner;

endmodule
